// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit.
//   - Condition codes decoded by branch_cond_eval.
//   - FSM state encodings for the flush sequencer.
package branch_resolve_unit_pkg;

   localparam logic [2:0] COND_NE     = 3'b000;
   localparam logic [2:0] COND_EQ     = 3'b001;
   localparam logic [2:0] COND_GT     = 3'b010;
   localparam logic [2:0] COND_LT     = 3'b011;
   localparam logic [2:0] COND_GTE    = 3'b100;
   localparam logic [2:0] COND_LTE    = 3'b101;
   localparam logic [2:0] COND_OVFL   = 3'b110;
   localparam logic [2:0] COND_UNCOND = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } brs_state_e;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// branch_cond_eval: purely combinational condition evaluator.
// Ports:
//   z, n, v  in   effective flags (already forwarded)
//   cond     in   3-bit condition code
//   taken    out  1 when the condition holds
// This block is also used by the branch predictor checker.
module branch_cond_eval
   import branch_resolve_unit_pkg::*;
(
   input  logic       z,
   input  logic       n,
   input  logic       v,
   input  logic [2:0] cond,
   output logic       taken
);

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_NE:     taken = ~z;
         COND_EQ:     taken = z;
         COND_GT:     taken = ~z & ~n;
         COND_LT:     taken = n;
         COND_GTE:    taken = z | (~z & ~n);
         COND_LTE:    taken = n | z;
         COND_OVFL:   taken = v;
         COND_UNCOND: taken = 1'b1;
         default:     taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: holds the architectural Z/N/V flags written by the
// ALU stage, resolves conditional branches from decode against those flags
// (with same-cycle forwarding of ALU flag writes), issues a one-cycle PC
// redirect and sequences a multi-cycle flush of younger instructions.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   stall                       freezes flags, FSM and counter
//   flag_we_{z,n,v}, alu_{z,n,v} ALU flag write enables and values
//   br_valid, br_cond,          branch request from decode
//   br_offset, br_pc_plus1
//   redirect, redirect_pc       one-cycle fetch redirect and its target
//   flush                       squash younger instructions
//   flag_z, flag_n, flag_v      architectural flags
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int OFF_W        = 9,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flag_we_z,
   input  logic              flag_we_n,
   input  logic              flag_we_v,
   input  logic              alu_z,
   input  logic              alu_n,
   input  logic              alu_v,
   input  logic              br_valid,
   input  logic [2:0]        br_cond,
   input  logic [OFF_W-1:0]  br_offset,
   input  logic [DATA_W-1:0] br_pc_plus1,
   output logic              redirect,
   output logic [DATA_W-1:0] redirect_pc,
   output logic              flush,
   output logic              flag_z,
   output logic              flag_n,
   output logic              flag_v
);

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   logic              eff_z;
   logic              eff_n;
   logic              eff_v;
   logic              taken;
   logic              accept;
   logic              take_branch;
   logic [DATA_W-1:0] target;
   brs_state_e        state;
   logic [2:0]        flush_cnt;

   // Forward the flags the instruction in EX is writing this cycle, so a
   // branch directly behind a flag-setting instruction needs no stall.
   assign eff_z = flag_we_z ? alu_z : flag_z;
   assign eff_n = flag_we_n ? alu_n : flag_n;
   assign eff_v = flag_we_v ? alu_v : flag_v;

   branch_cond_eval u_cond_eval (
      .z     (eff_z),
      .n     (eff_n),
      .v     (eff_v),
      .cond  (br_cond),
      .taken (taken)
   );

   // Target wraps silently modulo 2^DATA_W.
   assign target = br_pc_plus1
                 + {{(DATA_W - OFF_W){br_offset[OFF_W-1]}}, br_offset};

   // A branch seen while flushing is a squashed instruction.
   assign accept      = br_valid & ~stall & (state == ST_IDLE);
   assign take_branch = accept & taken;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_z      <= 1'b0;
         flag_n      <= 1'b0;
         flag_v      <= 1'b0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
         flush       <= 1'b0;
         state       <= ST_IDLE;
         flush_cnt   <= 3'd0;
      end else begin
         // EX holds an older, non-squashed instruction, so flag writes
         // continue even while flushing.
         if (!stall) begin
            if (flag_we_z) flag_z <= alu_z;
            if (flag_we_n) flag_n <= alu_n;
            if (flag_we_v) flag_v <= alu_v;
         end

         // Redirect is a pulse and is not held by stall.
         redirect <= take_branch;
         if (take_branch) redirect_pc <= target;

         case (state)
            ST_IDLE: begin
               if (take_branch) begin
                  state     <= ST_FLUSH;
                  flush     <= 1'b1;
                  flush_cnt <= FLUSH_INIT;
               end
            end
            ST_FLUSH: begin
               if (!stall) begin
                  if (flush_cnt == 3'd0) begin
                     state <= ST_IDLE;
                     flush <= 1'b0;
                  end else begin
                     flush_cnt <= flush_cnt - 3'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that tracks
// flags, the last target and the number of unstalled flush cycles left.
module tb_branch_resolve_unit;

   localparam int DATA_W       = 16;
   localparam int OFF_W        = 9;
   localparam int FLUSH_CYCLES = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall;
   logic              flag_we_z, flag_we_n, flag_we_v;
   logic              alu_z, alu_n, alu_v;
   logic              br_valid;
   logic [2:0]        br_cond;
   logic [OFF_W-1:0]  br_offset;
   logic [DATA_W-1:0] br_pc_plus1;
   logic              redirect;
   logic [DATA_W-1:0] redirect_pc;
   logic              flush;
   logic              flag_z, flag_n, flag_v;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state.
   logic              m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;
   logic              m_redirect = 1'b0;
   logic [DATA_W-1:0] m_pc = '0;
   int                m_rem = 0;   // unstalled flush cycles still owed

   always #5 clk = ~clk;

   branch_resolve_unit #(
      .DATA_W       (DATA_W),
      .OFF_W        (OFF_W),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flag_we_z   (flag_we_z),
      .flag_we_n   (flag_we_n),
      .flag_we_v   (flag_we_v),
      .alu_z       (alu_z),
      .alu_n       (alu_n),
      .alu_v       (alu_v),
      .br_valid    (br_valid),
      .br_cond     (br_cond),
      .br_offset   (br_offset),
      .br_pc_plus1 (br_pc_plus1),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .flush       (flush),
      .flag_z      (flag_z),
      .flag_n      (flag_n),
      .flag_v      (flag_v)
   );

   // Condition table written straight from the condition-code definitions.
   function automatic logic cond_holds(input logic [2:0] c, input logic z,
                                       input logic n, input logic v);
      case (c)
         3'd0:    return !z;
         3'd1:    return z;
         3'd2:    return !z && !n;
         3'd3:    return n;
         3'd4:    return z || (!z && !n);
         3'd5:    return n || z;
         3'd6:    return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic quiet();
      rst = 1'b0; stall = 1'b0;
      flag_we_z = 1'b0; flag_we_n = 1'b0; flag_we_v = 1'b0;
      alu_z = 1'b0; alu_n = 1'b0; alu_v = 1'b0;
      br_valid = 1'b0; br_cond = 3'd0; br_offset = '0; br_pc_plus1 = '0;
   endtask

   // Advance one clock with the current inputs and update the model.
   task automatic tick();
      logic ez, en, ev, acc, tk;
      int   sum;
      ez  = flag_we_z ? alu_z : m_z;
      en  = flag_we_n ? alu_n : m_n;
      ev  = flag_we_v ? alu_v : m_v;
      acc = br_valid && !stall && (m_rem == 0);
      tk  = acc && cond_holds(br_cond, ez, en, ev);
      sum = int'(br_pc_plus1) + int'($signed(br_offset));
      @(posedge clk);
      if (rst) begin
         m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
         m_redirect = 1'b0; m_pc = '0; m_rem = 0;
      end else begin
         if (!stall) begin
            m_z = ez; m_n = en; m_v = ev;
         end
         m_redirect = tk;
         if (tk) begin
            m_pc  = DATA_W'(sum & 32'hFFFF);
            m_rem = FLUSH_CYCLES;
         end else if (m_rem != 0 && !stall) begin
            m_rem = m_rem - 1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      quiet();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      vectors++;
      if ({redirect, flush, flag_z, flag_n, flag_v} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl got=%b want=00000", {redirect, flush, flag_z, flag_n, flag_v});
      end
      vectors++;
      if (redirect_pc !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_pc got=%h want=0000", redirect_pc);
      end
      flag_we_z = 1'b1; alu_z = 1'b1;
      tick();
      quiet();
      vectors++;
      if ({flag_z, flag_n, flag_v} !== 3'b100) begin
         miscompares++;
         $display("FAIL flag_write_z got=%b want=100", {flag_z, flag_n, flag_v});
      end
   endtask

   task automatic test_taken_gt();
      logic [2:0] fl;
      quiet();
      flag_we_z = 1'b1; flag_we_n = 1'b1;   // Z=0, N=0
      tick();
      quiet();
      br_valid = 1'b1; br_cond = 3'b010; br_offset = 9'h004; br_pc_plus1 = 16'h0010;
      tick();
      quiet();
      vectors++;
      if (redirect !== 1'b1 || redirect_pc !== 16'h0014) begin
         miscompares++;
         $display("FAIL gt_redirect got=%b/%h want=1/0014", redirect, redirect_pc);
      end
      fl[0] = flush;
      tick(); fl[1] = flush;
      vectors++;
      if (redirect !== 1'b0) begin
         miscompares++;
         $display("FAIL gt_pulse got=%b want=0", redirect);
      end
      tick(); fl[2] = flush;
      vectors++;
      if (fl !== 3'b011) begin
         miscompares++;
         $display("FAIL gt_flush_len got=%b want=011", fl);
      end
   endtask

   task automatic test_forward();
      quiet();
      flag_we_z = 1'b1; alu_z = 1'b1;
      tick();
      quiet();
      flag_we_z = 1'b1; alu_z = 1'b0;
      br_valid = 1'b1; br_cond = 3'b001; br_offset = 9'h010; br_pc_plus1 = 16'h0100;
      tick();
      quiet();
      vectors++;
      if (redirect !== 1'b0 || flush !== 1'b0 || flag_z !== 1'b0) begin
         miscompares++;
         $display("FAIL fwd_eq got=%b%b%b want=000", redirect, flush, flag_z);
      end
   endtask

   task automatic test_wrap();
      quiet();
      br_valid = 1'b1; br_cond = 3'b111; br_offset = 9'h1FF; br_pc_plus1 = 16'h0000;
      tick();
      quiet();
      vectors++;
      if (redirect !== 1'b1 || redirect_pc !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL wrap_neg got=%b/%h want=1/ffff", redirect, redirect_pc);
      end
      tick(); tick();
      br_valid = 1'b1; br_cond = 3'b111; br_offset = 9'h001; br_pc_plus1 = 16'hFFFF;
      tick();
      quiet();
      vectors++;
      if (redirect !== 1'b1 || redirect_pc !== 16'h0000) begin
         miscompares++;
         $display("FAIL wrap_pos got=%b/%h want=1/0000", redirect, redirect_pc);
      end
      tick(); tick();
   endtask

   task automatic test_stall_flush();
      logic [4:0] fl;
      logic [4:0] rd;
      quiet();
      br_valid = 1'b1; br_cond = 3'b111; br_offset = 9'h020; br_pc_plus1 = 16'h0200;
      tick();
      // Squashed branches keep arriving during the flush.
      br_offset = 9'h040; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); fl[i] = flush; rd[i] = redirect;
      end
      stall = 1'b0;
      tick(); fl[3] = flush; rd[3] = redirect;
      tick(); fl[4] = flush; rd[4] = redirect;
      quiet();
      vectors++;
      if (fl !== 5'b01111) begin
         miscompares++;
         $display("FAIL stall_flush got=%b want=01111", fl);
      end
      vectors++;
      if (rd !== 5'b00000 || redirect_pc !== 16'h0220) begin
         miscompares++;
         $display("FAIL squash_redirect got=%b/%h want=00000/0220", rd, redirect_pc);
      end
   endtask

   task automatic test_reset_mid_flush();
      quiet();
      flag_we_v = 1'b1; alu_v = 1'b1; flag_we_z = 1'b1; alu_z = 1'b1;
      tick();
      quiet();
      br_valid = 1'b1; br_cond = 3'b110; br_offset = 9'h008; br_pc_plus1 = 16'h1000;
      tick();
      quiet();
      vectors++;
      if (redirect !== 1'b1 || flush !== 1'b1 || redirect_pc !== 16'h1008) begin
         miscompares++;
         $display("FAIL ovfl_taken got=%b%b/%h want=11/1008", redirect, flush, redirect_pc);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if ({redirect, flush, flag_z, flag_n, flag_v} !== 5'b0 || redirect_pc !== 16'h0000) begin
         miscompares++;
         $display("FAIL rst_mid_flush got=%b/%h want=00000/0000",
                  {redirect, flush, flag_z, flag_n, flag_v}, redirect_pc);
      end
      // FSM back in IDLE: an immediate branch is accepted.
      br_valid = 1'b1; br_cond = 3'b111; br_offset = 9'h003; br_pc_plus1 = 16'h0030;
      tick();
      quiet();
      vectors++;
      if (redirect !== 1'b1 || redirect_pc !== 16'h0033) begin
         miscompares++;
         $display("FAIL idle_after_rst got=%b/%h want=1/0033", redirect, redirect_pc);
      end
      tick(); tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst         = ($urandom_range(0, 59) == 0);
         stall       = ($urandom_range(0, 3) == 0);
         flag_we_z   = 1'($urandom);
         flag_we_n   = 1'($urandom);
         flag_we_v   = 1'($urandom);
         alu_z       = 1'($urandom);
         alu_n       = 1'($urandom);
         alu_v       = 1'($urandom);
         br_valid    = ($urandom_range(0, 2) == 0);
         br_cond     = 3'($urandom);
         br_offset   = OFF_W'($urandom);
         br_pc_plus1 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : DATA_W'($urandom);
         tick();
         vectors++;
         if (redirect !== m_redirect) begin
            miscompares++;
            $display("FAIL rnd_redirect cyc=%0d got=%b want=%b", i, redirect, m_redirect);
         end
         vectors++;
         if (redirect_pc !== m_pc) begin
            miscompares++;
            $display("FAIL rnd_pc cyc=%0d got=%h want=%h", i, redirect_pc, m_pc);
         end
         vectors++;
         if (flush !== (m_rem != 0)) begin
            miscompares++;
            $display("FAIL rnd_flush cyc=%0d got=%b want=%b", i, flush, (m_rem != 0));
         end
         vectors++;
         if ({flag_z, flag_n, flag_v} !== {m_z, m_n, m_v}) begin
            miscompares++;
            $display("FAIL rnd_flags cyc=%0d got=%b want=%b", i,
                     {flag_z, flag_n, flag_v}, {m_z, m_n, m_v});
         end
      end
      quiet();
   endtask

   initial begin
      quiet();
      test_reset();
      test_taken_gt();
      test_forward();
      test_wrap();
      test_stall_flush();
      test_reset_mid_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
